// File: rtl/dsi_mem_arb_pkg.sv
// ============================================================================
// Module   : dsi_mem_arb_pkg
// Brief    : Shared types and constants for the DDR port arbiter
//            (state encoding, owner IDs, owner-queue entry width).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsi_mem_arb_pkg;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_t;

    // Owner tags stored in the in-order read queue
    localparam logic OWN_DMA = 1'b0;
    localparam logic OWN_CPU = 1'b1;

    // Queue entry = {owner, beats}; default burst width gives 1 + 7 bits
    localparam int DEF_BURST_W = 7;
    localparam int ENTRY_W     = 1 + DEF_BURST_W;

    // Entry width for an arbitrary burstcount width
    function automatic int entry_width(input int burst_w);
        return 1 + burst_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dsi_arb_owner_fifo.sv
// ============================================================================
// Module   : dsi_arb_owner_fifo
// Brief    : Synchronous FIFO holding {owner, beats} for each accepted read.
//            Power-of-two depth, full/empty flags, push and pop allowed in the
//            same cycle (including when full).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Qualify requests; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointer/occupancy registers; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while empty so no reset needed
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dsi_mem_arbiter.sv
// ============================================================================
// Module   : dsi_mem_arbiter
// Brief    : Two-master arbiter for the DDR command/response port.
//            m0 = display fetch DMA (burst reads, fixed high priority),
//            m1 = CPU (single-beat reads/writes). Read data is steered back
//            through an in-order owner queue with zero added latency.
//            Optional macro DSI_ARB_STARVE_GUARD_EN: after m1 has waited
//            STARVE_LIMIT cycles it is granted ahead of m0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_mem_arbiter
    import dsi_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int BURST_W      = 7,
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    output logic [BURST_W-1:0]  s_burstcount,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid,
    output logic                err_orphan
);

    localparam int Q_W = entry_width(BURST_W);

    arb_state_t         state_q, state_d;
    logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;   // 0 = head not yet loaded
    logic               err_q, err_d;

    logic               q_push, q_pop, q_full, q_empty;
    logic [Q_W-1:0]     q_push_data, q_head;
    logic               head_owner;
    logic [BURST_W-1:0] head_beats, remaining;
    logic               cmd_accept;
    logic               m0_ok, m1_ok;
    logic               m1_starved;

    assign head_owner = q_head[Q_W-1];
    assign head_beats = q_head[BURST_W-1:0];
    assign err_orphan = err_q;

`ifdef DSI_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;

    // Count cycles m1 is asking but not holding the bus; saturate at the limit
    always_comb begin
        starve_d = starve_q;
        if (state_q == G1) begin
            starve_d = '0;
        end else if ((m1_read || m1_write) && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign m1_starved = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;
    assign m1_starved          = 1'b0;
`endif

    // Command mux: only the granted master reaches the DDR port
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        s_burstcount   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_q)
            G0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_burstcount   = m0_burstcount;
                m0_waitrequest = s_waitrequest;
            end
            G1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_burstcount   = BURST_W'(1);
                m1_waitrequest = s_waitrequest;
            end
            default: ;
        endcase
    end

    assign cmd_accept = (s_read || s_write) && !s_waitrequest;
    assign m0_ok      = m0_read && !q_full;
    assign m1_ok      = m1_write || (m1_read && !q_full);

    // Grant selection and owner-queue push on command acceptance
    always_comb begin
        state_d     = state_q;
        q_push      = 1'b0;
        q_push_data = {OWN_DMA, m0_burstcount};
        case (state_q)
            IDLE: begin
                if (m1_starved && m1_ok) begin
                    state_d = G1;
                end else if (m0_ok) begin
                    state_d = G0;
                end else if (m1_ok) begin
                    state_d = G1;
                end
            end
            G0: begin
                // A withdrawn request frees the bus rather than wedging it
                if (!m0_read) begin
                    state_d = IDLE;
                end else if (cmd_accept) begin
                    q_push  = 1'b1;
                    state_d = IDLE;
                end
            end
            G1: begin
                if (!(m1_read || m1_write)) begin
                    state_d = IDLE;
                end else if (cmd_accept) begin
                    q_push      = m1_read;
                    q_push_data = {OWN_CPU, BURST_W'(1)};
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response steering: head owner gets the valid; pop on the last beat
    always_comb begin
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        q_pop            = 1'b0;
        beat_cnt_d       = beat_cnt_q;
        err_d            = err_q;
        remaining        = (beat_cnt_q == '0) ? head_beats : beat_cnt_q;
        if (s_readdatavalid) begin
            if (q_empty) begin
                err_d = 1'b1;
            end else begin
                m0_readdatavalid = (head_owner == OWN_DMA);
                m1_readdatavalid = (head_owner == OWN_CPU);
                if (remaining <= BURST_W'(1)) begin
                    q_pop      = 1'b1;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = remaining - BURST_W'(1);
                end
            end
        end
    end

    // Arbiter state, beat counter and sticky orphan flag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    dsi_arb_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (Q_W)
    ) u_owner_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .pop_data  (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_dsi_mem_arbiter.sv
// ============================================================================
// Module   : tb_dsi_mem_arbiter
// Brief    : Self-checking bench for dsi_mem_arbiter. A transaction-level
//            model (who holds the bus, list of outstanding reads with beats
//            left) predicts every output each cycle; directed scenarios pin
//            literal values. Honours DSI_ARB_STARVE_GUARD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsi_mem_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int BURST_W      = 7;
    localparam int MAX_OUTST    = 4;
    localparam int STARVE_LIMIT = 64;

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic [ADDR_W-1:0]   m0_address;
    logic                m0_read;
    logic [BURST_W-1:0]  m0_burstcount;
    logic                m0_waitrequest;
    logic [DATA_W-1:0]   m0_readdata;
    logic                m0_readdatavalid;
    logic [ADDR_W-1:0]   m1_address;
    logic                m1_read;
    logic                m1_write;
    logic [DATA_W-1:0]   m1_writedata;
    logic [DATA_W/8-1:0] m1_byteenable;
    logic                m1_waitrequest;
    logic [DATA_W-1:0]   m1_readdata;
    logic                m1_readdatavalid;
    logic [ADDR_W-1:0]   s_address;
    logic                s_read;
    logic                s_write;
    logic [DATA_W-1:0]   s_writedata;
    logic [DATA_W/8-1:0] s_byteenable;
    logic [BURST_W-1:0]  s_burstcount;
    logic                s_waitrequest;
    logic [DATA_W-1:0]   s_readdata;
    logic                s_readdatavalid;
    logic                err_orphan;

    dsi_mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .BURST_W      (BURST_W),
        .MAX_OUTST    (MAX_OUTST),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_burstcount    (m0_burstcount),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_burstcount     (s_burstcount),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    int  holder;          // -1 nobody, 0 DMA, 1 CPU
    int  oq_own[$];       // outstanding reads, oldest first
    int  oq_beats[$];     // beats still owed per outstanding read
    bit  err_m;
    int  starve_m;
    int  slave_beats;     // beats the DDR side still has to return

    // ---------------- stimulus state ----------------
    bit                  m0_pend, m1_pend, m1_is_wr, m0_stream, rnd_mode;
    logic [31:0]         m0_a, m1_a, m1_d, man_data;
    logic [BURST_W-1:0]  m0_b;
    logic [3:0]          m1_be;
    int                  wait_pct, rsp_pct, man_rdv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        holder = -1;
        oq_own.delete();
        oq_beats.delete();
        err_m    = 1'b0;
        starve_m = 0;
        m0_pend  = 1'b0;
        m1_pend  = 1'b0;
    endtask

    // Apply this cycle's inputs
    task automatic drive();
        if (rnd_mode) begin
            if (!m0_pend && $urandom_range(99) < 35) begin
                m0_pend = 1'b1;
                m0_a    = $urandom;
                m0_b    = ($urandom_range(9) == 0) ? BURST_W'(64) : BURST_W'($urandom_range(1, 8));
            end
            if (!m1_pend && $urandom_range(99) < 30) begin
                m1_pend  = 1'b1;
                m1_is_wr = 1'($urandom_range(1));
                m1_a     = $urandom;
                m1_d     = $urandom;
                m1_be    = 4'($urandom_range(1, 15));
            end
        end
        if (m0_stream && !m0_pend) begin
            m0_pend = 1'b1;
            m0_b    = BURST_W'(1);
            m0_a    = m0_a + 32'd64;
        end
        m0_read       = m0_pend;
        m0_address    = m0_a;
        m0_burstcount = m0_b;
        m1_read       = m1_pend && !m1_is_wr;
        m1_write      = m1_pend && m1_is_wr;
        m1_address    = m1_a;
        m1_writedata  = m1_d;
        m1_byteenable = m1_be;
        s_waitrequest = ($urandom_range(99) < wait_pct);
        if (man_rdv >= 0) begin
            s_readdatavalid = man_rdv[0];
            s_readdata      = man_data;
        end else begin
            s_readdatavalid = (slave_beats > 0) && ($urandom_range(99) < rsp_pct);
            s_readdata      = $urandom;
        end
    endtask

    // Compare every DUT output with what the model says it must be now
    task automatic compare();
        logic e_sr, e_sw, e_w0, e_w1, e_v0, e_v1;
        e_sr = (holder == 0) ? m0_read : (holder == 1) ? m1_read : 1'b0;
        e_sw = (holder == 1) ? m1_write : 1'b0;
        e_w0 = (holder == 0) ? s_waitrequest : 1'b1;
        e_w1 = (holder == 1) ? s_waitrequest : 1'b1;
        chk("s_read", s_read, e_sr);
        chk("s_write", s_write, e_sw);
        chk("m0_waitrequest", m0_waitrequest, e_w0);
        chk("m1_waitrequest", m1_waitrequest, e_w1);
        if (holder == 0) begin
            chk("s_address_m0", s_address, m0_address);
            chk("s_burstcount_m0", s_burstcount, m0_burstcount);
        end
        if (holder == 1) begin
            chk("s_address_m1", s_address, m1_address);
            chk("s_burstcount_m1", s_burstcount, 1);
            if (m1_write) begin
                chk("s_writedata", s_writedata, m1_writedata);
                chk("s_byteenable", s_byteenable, m1_byteenable);
            end
        end
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        if (s_readdatavalid && oq_own.size() != 0) begin
            if (oq_own[0] == 0) e_v0 = 1'b1;
            else                e_v1 = 1'b1;
        end
        chk("m0_readdatavalid", m0_readdatavalid, e_v0);
        chk("m1_readdatavalid", m1_readdatavalid, e_v1);
        chk("m0_readdata", m0_readdata, s_readdata);
        chk("m1_readdata", m1_readdata, s_readdata);
        chk("err_orphan", err_orphan, err_m);
    endtask

    // Advance the model across the coming clock edge
    task automatic model_update();
        bit full;
        int st_before;
        if (s_readdatavalid && slave_beats > 0) slave_beats--;
        if (rst_in) begin
            model_reset();
            return;
        end
        full      = (oq_own.size() >= MAX_OUTST);
        st_before = starve_m;
        if (s_readdatavalid) begin
            if (oq_own.size() == 0) begin
                err_m = 1'b1;
            end else begin
                oq_beats[0]--;
                if (oq_beats[0] == 0) begin
                    void'(oq_own.pop_front());
                    void'(oq_beats.pop_front());
                end
            end
        end
        if (holder == 1) starve_m = 0;
        else if ((m1_read || m1_write) && starve_m < STARVE_LIMIT) starve_m++;
        assert (!(holder == 0 && !m0_read)) else $error("bench withdrew m0 request while granted");
        if (holder == 0) begin
            if (m0_read && !s_waitrequest) begin
                oq_own.push_back(0);
                oq_beats.push_back(int'(m0_burstcount));
                slave_beats += int'(m0_burstcount);
                m0_pend = 1'b0;
                holder  = -1;
            end
        end else if (holder == 1) begin
            if ((m1_read || m1_write) && !s_waitrequest) begin
                if (m1_read) begin
                    oq_own.push_back(1);
                    oq_beats.push_back(1);
                    slave_beats += 1;
                end
                m1_pend = 1'b0;
                holder  = -1;
            end
        end else begin
            bit m1_can;
            m1_can = m1_write || (m1_read && !full);
`ifdef DSI_ARB_STARVE_GUARD_EN
            if (st_before >= STARVE_LIMIT && m1_can) holder = 1;
            else
`endif
            if (m0_read && !full) holder = 0;
            else if (m1_can)      holder = 1;
        end
        if (st_before < 0) $error("starve model underflow");
    endtask

    task automatic cycle();
        drive();
        #1;
        compare();
        model_update();
    endtask

    task automatic reset_dut();
        rst_in    = 1'b1;
        model_reset();
        man_rdv   = 0;
        m0_stream = 1'b0;
        rnd_mode  = 1'b0;
        repeat (2) begin
            cycle();
            @(negedge clk_in);
        end
        rst_in      = 1'b0;
        slave_beats = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int at;
        m0_a = 32'h0; m1_a = 32'h0; m1_d = 32'h0; man_data = 32'h0;
        m0_b = BURST_W'(1); m1_be = 4'hF; m1_is_wr = 1'b0;
        wait_pct = 0; rsp_pct = 0; man_rdv = 0; slave_beats = 0;
        rst_in = 1'b1;
        model_reset();
        drive();
        @(negedge clk_in);
        reset_dut();

        // ---- reset state ----
        cycle();
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_err", err_orphan, 0);
        @(negedge clk_in);

        // ---- CPU single read, data 3 cycles after accept ----
        m1_pend = 1'b1; m1_is_wr = 1'b0; m1_a = 32'h2000_0010;
        cycle(); @(negedge clk_in);
        cycle();
        chk("t1_s_read", s_read, 1);
        chk("t1_m1_wait", m1_waitrequest, 0);
        chk("t1_burst", s_burstcount, 1);
        @(negedge clk_in);
        repeat (2) begin cycle(); @(negedge clk_in); end
        man_rdv = 1; man_data = 32'hDEAD_BEEF;
        cycle();
        chk("t1_m1_rdv", m1_readdatavalid, 1);
        chk("t1_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
        chk("t1_m0_rdv", m0_readdatavalid, 0);
        @(negedge clk_in);
        man_rdv = 0;
        cycle();
        chk("t1_m1_rdv_off", m1_readdatavalid, 0);
        @(negedge clk_in);

        // ---- simultaneous m0 burst-8 and m1 read ----
        reset_dut();
        m0_pend = 1'b1; m0_a = 32'h0100_0000; m0_b = BURST_W'(8);
        m1_pend = 1'b1; m1_is_wr = 1'b0; m1_a = 32'h2000_0020;
        cycle(); @(negedge clk_in);
        cycle();
        chk("t2_g0_s_read", s_read, 1);
        chk("t2_g0_burst", s_burstcount, 8);
        chk("t2_g0_m0_wait", m0_waitrequest, 0);
        chk("t2_g0_m1_wait", m1_waitrequest, 1);
        @(negedge clk_in);
        cycle();
        chk("t2_gap_m1_wait", m1_waitrequest, 1);
        chk("t2_gap_s_read", s_read, 0);
        @(negedge clk_in);
        cycle();
        chk("t2_g1_m1_wait", m1_waitrequest, 0);
        chk("t2_g1_addr", s_address, 32'h2000_0020);
        @(negedge clk_in);
        for (int i = 0; i < 9; i++) begin
            man_rdv = 1; man_data = 32'h100 + i;
            cycle();
            chk("t2_beat_m0", m0_readdatavalid, (i < 8));
            chk("t2_beat_m1", m1_readdatavalid, (i == 8));
            @(negedge clk_in);
        end
        man_rdv = 0;

        // ---- queue full: reads blocked, write still accepted ----
        reset_dut();
        for (int k = 0; k < MAX_OUTST; k++) begin
            m1_pend = 1'b1; m1_is_wr = 1'b0; m1_a = 32'h3000_0000 + 32'(k * 4);
            for (int c = 0; c < 6 && m1_pend; c++) begin
                cycle(); @(negedge clk_in);
            end
            if (m1_pend) begin
                n_checks++; n_fail++;
                $display("FAIL t3_fill: read %0d not accepted within 6 cycles", k);
            end
        end
        m0_pend = 1'b1; m0_a = 32'h0200_0000; m0_b = BURST_W'(5);
        m1_pend = 1'b1; m1_is_wr = 1'b0;
        repeat (4) begin
            cycle();
            chk("t3_m0_blocked", m0_waitrequest, 1);
            chk("t3_m1_rd_blocked", m1_waitrequest, 1);
            chk("t3_no_s_read", s_read, 0);
            @(negedge clk_in);
        end
        m1_is_wr = 1'b1; m1_a = 32'h1000_0000; m1_d = 32'h41; m1_be = 4'hF;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cycle();
            if (s_write && !m1_waitrequest && !seen) begin
                seen = 1'b1;
                chk("t3_wr_addr", s_address, 32'h1000_0000);
                chk("t3_wr_data", s_writedata, 32'h41);
            end
            @(negedge clk_in);
        end
        chk("t3_write_granted", seen, 1);
        repeat (2) begin
            cycle();
            chk("t3_m0_still_blocked", m0_waitrequest, 1);
            @(negedge clk_in);
        end

        // ---- reset mid-burst, 3 beats arrive afterwards ----
        reset_dut();
        m0_pend = 1'b1; m0_a = 32'h0400_0000; m0_b = BURST_W'(5);
        cycle(); @(negedge clk_in);
        cycle(); @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            man_rdv = 1; man_data = 32'hA0 + i;
            cycle();
            chk("t4_pre_m0_rdv", m0_readdatavalid, 1);
            @(negedge clk_in);
        end
        rst_in = 1'b1; model_reset(); man_rdv = 0;
        cycle();
        chk("t4_rst_m0_wait", m0_waitrequest, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            man_rdv = 1; man_data = 32'hB0 + i;
            cycle();
            chk("t4_orphan_m0_rdv", m0_readdatavalid, 0);
            chk("t4_orphan_m1_rdv", m1_readdatavalid, 0);
            @(negedge clk_in);
        end
        man_rdv = 0;
        cycle();
        chk("t4_err_orphan", err_orphan, 1);
        @(negedge clk_in);

        // ---- continuous m0 traffic vs. waiting m1 read ----
        reset_dut();
        man_rdv = -1; rsp_pct = 100; wait_pct = 0;
        m0_stream = 1'b1; m0_a = 32'h0500_0000;
        m1_pend = 1'b1; m1_is_wr = 1'b0; m1_a = 32'h2000_0040;
        seen = 1'b0; at = -1;
`ifdef DSI_ARB_STARVE_GUARD_EN
        for (int c = 0; c < 80 && !seen; c++) begin
            cycle();
            if (!m1_waitrequest) begin seen = 1'b1; at = c; end
            @(negedge clk_in);
        end
        chk("t5_starve_grant_in_time", (seen && at <= STARVE_LIMIT + 2), 1);
`else
        for (int c = 0; c < 100; c++) begin
            cycle();
            if (!m1_waitrequest) seen = 1'b1;
            @(negedge clk_in);
        end
        chk("t5_m1_stalled", seen, 0);
        m0_stream = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            cycle();
            if (!m1_waitrequest) seen = 1'b1;
            @(negedge clk_in);
        end
        chk("t5_m1_after_m0_stops", seen, 1);
`endif
        m0_stream = 1'b0;

        // ---- randomized traffic against the model ----
        reset_dut();
        man_rdv = -1; rsp_pct = 60; wait_pct = 25; rnd_mode = 1'b1;
        repeat (3000) begin
            cycle();
            @(negedge clk_in);
        end
        rnd_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
